cp_writeback_stage: RTL and testbench

- Final pipeline stage that directly feeds the 32x32 register file write port (rd_addr/rd_data/rd_we).
- Arbitrates between ALU results and load-unit results, and formats raw load words (byte/half select, sign/zero extend).
- Maintains a 32-bit pending-write scoreboard that decode uses for RAW stalls.
- Exposes the in-flight write as a forwarding source, because the register file only updates on the edge after rd_we is presented.

---
 rtl/cp_pkg.sv | 13 +
 rtl/cp_load_formatter.sv | 32 +++
 rtl/cp_writeback_stage.sv | 118 +++++++++++
 tb/tb_cp_writeback_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared types and load-type encodings for the writeback stage.
package cp_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/cp_load_formatter.sv
// Selects and extends the addressed byte/half of an aligned load word.
module cp_load_formatter
  import cp_pkg::*;
(
  input  xlen_t      rdata,
  input  logic [2:0] funct3,
  input  logic [1:0] byte_off,
  output xlen_t      data,
  output logic       illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{byte_off, 3'b000} +: 8];
  // Halfword loads are assumed aligned, so only byte_off[1] picks the half.
  assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0, half_sel};
      LW:      data = rdata;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cp_writeback_stage.sv
// Final pipeline stage: LSU/ALU arbitration, register-file write port,
// forwarding source and pending-write scoreboard.
module cp_writeback_stage
  import cp_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             alu_valid_i,
  output logic             alu_ready_o,
  input  logic [4:0]       alu_rd_addr_i,
  input  logic [XLEN-1:0]  alu_data_i,

  input  logic             lsu_valid_i,
  input  logic [4:0]       lsu_rd_addr_i,
  input  logic [XLEN-1:0]  lsu_rdata_i,
  input  logic [2:0]       lsu_funct3_i,
  input  logic [1:0]       lsu_byte_off_i,
  output logic             lsu_err_o,

  input  logic             issue_valid_i,
  input  logic [4:0]       issue_rd_addr_i,

  output logic [4:0]       rd_addr_o,
  output logic [XLEN-1:0]  rd_data_o,
  output logic             rd_we_o,

  output logic             fwd_valid_o,
  output logic [4:0]       fwd_addr_o,
  output logic [XLEN-1:0]  fwd_data_o,

  output logic [NREGS-1:0] pending_o
);

  logic             wb_valid_q, wb_valid_d;
  reg_addr_t        wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             err_q, err_d;
  logic [NREGS-1:0] pending_q, pending_d;

  xlen_t ld_data;
  logic  ld_illegal;
  logic  wb_we;

  cp_load_formatter u_load_formatter (
    .rdata    (lsu_rdata_i),
    .funct3   (lsu_funct3_i),
    .byte_off (lsu_byte_off_i),
    .data     (ld_data),
    .illegal  (ld_illegal)
  );

  // Loads cannot be back-pressured, so they always win.
  assign alu_ready_o = !lsu_valid_i;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    if (lsu_valid_i) begin
      if (ld_illegal) begin
        err_d = 1'b1;
      end else begin
        wb_valid_d = 1'b1;
        wb_addr_d  = lsu_rd_addr_i;
        wb_data_d  = ld_data;
      end
    end else if (alu_valid_i) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = alu_rd_addr_i;
      wb_data_d  = alu_data_i;
    end
  end

  assign wb_we = wb_valid_q && (wb_addr_q != '0);

  // Set after clear: a same-cycle issue to the retiring register is a new producer.
  always_comb begin
    pending_d = pending_q;
    if (wb_we) begin
      pending_d[wb_addr_q] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_addr_i != '0)) begin
      pending_d[issue_rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      pending_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
    end
  end

  assign rd_addr_o   = wb_addr_q;
  assign rd_data_o   = wb_data_q;
  assign rd_we_o     = wb_we;
  assign fwd_valid_o = wb_we;
  assign fwd_addr_o  = wb_addr_q;
  assign fwd_data_o  = wb_data_q;
  assign lsu_err_o   = err_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_cp_writeback_stage.sv
// Directed bench for cp_writeback_stage with a behavioural reference model.
module tb_cp_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rdata_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_byte_off_i;
  logic        lsu_err_o;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_addr_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
  logic [31:0] pending_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp_writeback_stage dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid_i     (alu_valid_i),
    .alu_ready_o     (alu_ready_o),
    .alu_rd_addr_i   (alu_rd_addr_i),
    .alu_data_i      (alu_data_i),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_rd_addr_i   (lsu_rd_addr_i),
    .lsu_rdata_i     (lsu_rdata_i),
    .lsu_funct3_i    (lsu_funct3_i),
    .lsu_byte_off_i  (lsu_byte_off_i),
    .lsu_err_o       (lsu_err_o),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
    .rd_we_o         (rd_we_o),
    .fwd_valid_o     (fwd_valid_o),
    .fwd_addr_o      (fwd_addr_o),
    .fwd_data_o      (fwd_data_o),
    .pending_o       (pending_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference load formatting by shift-and-mask.
  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off, output bit ill);
    logic [31:0] b;
    logic [31:0] h;
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    ill = 1'b0;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      3'd2:    return w;
      default: begin ill = 1'b1; return 32'h0; end
    endcase
  endfunction

  // Model state: what is being written this cycle, what is outstanding.
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  bit [31:0]   m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we = 0; m_addr = '0; m_data = '0; m_err = 0; m_pend = '0;
    end else begin
      bit          ill;
      logic [31:0] v;
      if (m_we) m_pend[m_addr] = 1'b0;
      if (issue_valid_i && issue_rd_addr_i != 0) m_pend[issue_rd_addr_i] = 1'b1;
      m_we  = 0;
      m_err = 0;
      if (lsu_valid_i) begin
        v = ref_fmt(lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i, ill);
        if (ill) m_err = 1;
        else begin
          m_we = (lsu_rd_addr_i != 0); m_addr = lsu_rd_addr_i; m_data = v;
        end
      end else if (alu_valid_i) begin
        m_we = (alu_rd_addr_i != 0); m_addr = alu_rd_addr_i; m_data = alu_data_i;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_we", {31'h0, rd_we_o}, {31'h0, m_we});
    chk("model_fwd_valid", {31'h0, fwd_valid_o}, {31'h0, m_we});
    if (m_we) begin
      chk("model_addr", {27'h0, rd_addr_o}, {27'h0, m_addr});
      chk("model_data", rd_data_o, m_data);
      chk("model_fwd_addr", {27'h0, fwd_addr_o}, {27'h0, m_addr});
      chk("model_fwd_data", fwd_data_o, m_data);
    end
    chk("model_pending", pending_o, m_pend);
    chk("model_err", {31'h0, lsu_err_o}, {31'h0, m_err});
    chk("model_alu_ready", {31'h0, alu_ready_o}, {31'h0, !lsu_valid_i});
  end

  task automatic idle();
    alu_valid_i = 0; alu_rd_addr_i = '0; alu_data_i = '0;
    lsu_valid_i = 0; lsu_rd_addr_i = '0; lsu_rdata_i = '0;
    lsu_funct3_i = 3'd2; lsu_byte_off_i = '0;
    issue_valid_i = 0; issue_rd_addr_i = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid_i = 1; alu_rd_addr_i = rd; alu_data_i = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] w, input logic [2:0] f3,
                     input logic [1:0] off);
    lsu_valid_i = 1; lsu_rd_addr_i = rd; lsu_rdata_i = w;
    lsu_funct3_i = f3; lsu_byte_off_i = off;
  endtask

  logic [2:0]  fmt_f3  [5] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5};
  logic [1:0]  fmt_off [5] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0};
  logic [31:0] fmt_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                               32'hFFFF_80FF, 32'h0000_017F};

  initial begin
    logic [31:0] pend_save;
    rst = 1'b1;
    idle();
    #2;
    chk("reset_we", {31'h0, rd_we_o}, 32'h0);
    chk("reset_pending", pending_o, 32'h0);
    chk("reset_err", {31'h0, lsu_err_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ALU only
    @(negedge clk); issue_valid_i = 1; issue_rd_addr_i = 5'd5;
    @(negedge clk); idle(); alu(5'd5, 32'hDEAD_BEEF);
    #1 chk("t1_alu_ready", {31'h0, alu_ready_o}, 32'h1);
    @(negedge clk);
    chk("t1_we", {31'h0, rd_we_o}, 32'h1);
    chk("t1_addr", {27'h0, rd_addr_o}, 32'd5);
    chk("t1_data", rd_data_o, 32'hDEAD_BEEF);
    chk("t1_pend_set", {31'h0, pending_o[5]}, 32'h1);
    idle();
    @(negedge clk);
    chk("t1_pend_clr", {31'h0, pending_o[5]}, 32'h0);

    // Collision: LSU wins, ALU held
    lsu(5'd3, 32'h1234_5678, 3'd2, 2'd1); alu(5'd4, 32'h1);
    #1 chk("t2_alu_ready", {31'h0, alu_ready_o}, 32'h0);
    @(negedge clk);
    chk("t2_first_addr", {27'h0, rd_addr_o}, 32'd3);
    chk("t2_first_data", rd_data_o, 32'h1234_5678);
    lsu_valid_i = 0;
    @(negedge clk);
    chk("t2_second_addr", {27'h0, rd_addr_o}, 32'd4);
    chk("t2_second_data", rd_data_o, 32'h1);
    idle();

    // Load formatting
    for (int i = 0; i < 5; i++) begin
      lsu(5'd10, 32'h80FF_017F, fmt_f3[i], fmt_off[i]);
      @(negedge clk);
      chk($sformatf("t3_fmt%0d", i), rd_data_o, fmt_exp[i]);
    end
    idle();

    // x0 write and illegal load
    @(negedge clk);
    pend_save = pending_o;
    alu(5'd0, 32'h55);
    @(negedge clk);
    chk("t4_x0_we", {31'h0, rd_we_o}, 32'h0);
    chk("t4_x0_fwd", {31'h0, fwd_valid_o}, 32'h0);
    chk("t4_x0_pend", pending_o, pend_save);
    idle(); lsu(5'd6, 32'hFFFF_FFFF, 3'd3, 2'd0); alu(5'd9, 32'h9);
    @(negedge clk);
    chk("t4_err_hi", {31'h0, lsu_err_o}, 32'h1);
    chk("t4_err_we", {31'h0, rd_we_o}, 32'h0);
    idle();
    @(negedge clk);
    chk("t4_err_lo", {31'h0, lsu_err_o}, 32'h0);

    // Scoreboard set/clear race on x7
    issue_valid_i = 1; issue_rd_addr_i = 5'd7; alu(5'd7, 32'h7);
    @(negedge clk); alu_valid_i = 0;
    @(negedge clk);
    chk("t5_race_set_wins", {31'h0, pending_o[7]}, 32'h1);
    issue_valid_i = 0; alu(5'd7, 32'h77);
    @(negedge clk); alu_valid_i = 0;
    @(negedge clk);
    chk("t5_final_clear", {31'h0, pending_o[7]}, 32'h0);

    // Asynchronous reset mid-cycle
    issue_valid_i = 1; issue_rd_addr_i = 5'd5;
    @(negedge clk); issue_rd_addr_i = 5'd7;
    @(negedge clk); issue_valid_i = 0; alu(5'd9, 32'hAB);
    @(posedge clk); #2;
    chk("t6_pre_we", {31'h0, rd_we_o}, 32'h1);
    chk("t6_pre_pend", pending_o, 32'h0000_00A0);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", {31'h0, rd_we_o}, 32'h0);
    chk("t6_rst_fwd", {31'h0, fwd_valid_o}, 32'h0);
    chk("t6_rst_pend", pending_o, 32'h0);
    @(negedge clk); idle(); rst = 1'b0;
    @(negedge clk); alu(5'd8, 32'h77);
    @(negedge clk); idle();
    chk("t6_after_we", {31'h0, rd_we_o}, 32'h1);
    chk("t6_after_data", rd_data_o, 32'h77);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
